stack_reg_file_p: RTL and testbench

- Parametrised next-generation operand stack for the single-cycle stack CPU.
- Adds the following over the previous stack register file:
  - Configurable width and depth.
  - Encoded operation port covering push, pops and combined pop-then-push.
  - Full/empty/count status.
  - Overflow, underflow and illegal-op detection with a sticky error flag.
- Top two entries are held in registers, so both operands are readable combinationally in the cycle the CPU issues an op.

---
 rtl/stack_reg_file_p.sv | 202 ++++++++++++++++++++
 tb/tb_stack_reg_file_p.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/stack_reg_file_p.sv
// Parametrised operand stack: TOS/NOS in registers, deeper entries in an array.
// Define STACK_EXT_OPS_EN to implement DUP/SWAP; otherwise ops 110/111 are illegal.
module stack_reg_file_p #(
  parameter int unsigned DBITS = 32,
  parameter int unsigned DEPTH = 256,
  parameter int unsigned CBITS = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       op,
  input  logic [DBITS-1:0] din,
  input  logic             clr_err,
  output logic [DBITS-1:0] dout1,
  output logic [DBITS-1:0] dout2,
  output logic [CBITS-1:0] count,
  output logic             full,
  output logic             empty,
  output logic             err,
  output logic [1:0]       err_code
);

  localparam int unsigned AW = $clog2(DEPTH - 2);

  localparam logic [2:0] OP_NOP      = 3'b000;
  localparam logic [2:0] OP_PUSH     = 3'b001;
  localparam logic [2:0] OP_POP1     = 3'b010;
  localparam logic [2:0] OP_POP2     = 3'b011;
  localparam logic [2:0] OP_POP1PUSH = 3'b100;
  localparam logic [2:0] OP_POP2PUSH = 3'b101;
  localparam logic [2:0] OP_DUP      = 3'b110;
  localparam logic [2:0] OP_SWAP     = 3'b111;

  localparam logic [1:0] ERR_UNF = 2'b01;
  localparam logic [1:0] ERR_OVF = 2'b10;
  localparam logic [1:0] ERR_ILL = 2'b11;

  logic [DBITS-1:0] tos_q, tos_d;
  logic [DBITS-1:0] nos_q, nos_d;
  logic [CBITS-1:0] count_q, count_d;
  logic             err_q, err_d;
  logic [1:0]       err_code_q, err_code_d;

  logic [DBITS-1:0] mem [DEPTH-2];
  logic             mem_we;
  logic [AW-1:0]    mem_wa;
  logic [DBITS-1:0] mem_wd;

  logic             is_full, is_empty, ge2, ge3, ge4;
  logic [AW-1:0]    idx_push, idx3, idx4;
  logic [DBITS-1:0] rd3, rd4;
  logic             fault;
  logic [1:0]       fault_code;

  assign is_full  = (count_q == CBITS'(DEPTH));
  assign is_empty = (count_q == CBITS'(0));
  assign ge2      = (count_q >= CBITS'(2));
  assign ge3      = (count_q >= CBITS'(3));
  assign ge4      = (count_q >= CBITS'(4));

  // Array slot receiving NOS on a push, and the two entries below NOS.
  assign idx_push = AW'(count_q - CBITS'(2));
  assign idx3     = AW'(count_q - CBITS'(3));
  assign idx4     = AW'(count_q - CBITS'(4));
  assign rd3      = mem[idx3];
  assign rd4      = mem[idx4];

  always_comb begin
    tos_d      = tos_q;
    nos_d      = nos_q;
    count_d    = count_q;
    err_d      = err_q;
    err_code_d = err_code_q;
    mem_we     = 1'b0;
    mem_wa     = idx_push;
    mem_wd     = nos_q;
    fault      = 1'b0;
    fault_code = 2'b00;

    case (op)
      OP_NOP: ;
      OP_PUSH: begin
        if (is_full) begin
          fault      = 1'b1;
          fault_code = ERR_OVF;
        end else begin
          mem_we  = ge2;
          nos_d   = tos_q;
          tos_d   = din;
          count_d = count_q + CBITS'(1);
        end
      end
      OP_POP1: begin
        if (is_empty) begin
          fault      = 1'b1;
          fault_code = ERR_UNF;
        end else begin
          tos_d   = nos_q;
          nos_d   = ge3 ? rd3 : nos_q;
          count_d = count_q - CBITS'(1);
        end
      end
      OP_POP2: begin
        if (!ge2) begin
          fault      = 1'b1;
          fault_code = ERR_UNF;
        end else begin
          tos_d   = ge3 ? rd3 : tos_q;
          nos_d   = ge4 ? rd4 : nos_q;
          count_d = count_q - CBITS'(2);
        end
      end
      OP_POP1PUSH: begin
        if (is_empty) begin
          fault      = 1'b1;
          fault_code = ERR_UNF;
        end else begin
          tos_d = din;
        end
      end
      OP_POP2PUSH: begin
        if (!ge2) begin
          fault      = 1'b1;
          fault_code = ERR_UNF;
        end else begin
          tos_d   = din;
          nos_d   = ge3 ? rd3 : nos_q;
          count_d = count_q - CBITS'(1);
        end
      end
`ifdef STACK_EXT_OPS_EN
      OP_DUP: begin
        if (is_empty) begin
          fault      = 1'b1;
          fault_code = ERR_UNF;
        end else if (is_full) begin
          fault      = 1'b1;
          fault_code = ERR_OVF;
        end else begin
          mem_we  = ge2;
          nos_d   = tos_q;
          count_d = count_q + CBITS'(1);
        end
      end
      OP_SWAP: begin
        if (!ge2) begin
          fault      = 1'b1;
          fault_code = ERR_UNF;
        end else begin
          tos_d = nos_q;
          nos_d = tos_q;
        end
      end
`else
      OP_DUP, OP_SWAP: begin
        fault      = 1'b1;
        fault_code = ERR_ILL;
      end
`endif
    endcase

    // First cause is kept unless cleared this same cycle.
    if (fault) begin
      err_d      = 1'b1;
      err_code_d = (err_q && !clr_err) ? err_code_q : fault_code;
    end else if (clr_err) begin
      err_d      = 1'b0;
      err_code_d = 2'b00;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      tos_q      <= '0;
      nos_q      <= '0;
      count_q    <= '0;
      err_q      <= 1'b0;
      err_code_q <= 2'b00;
    end else begin
      tos_q      <= tos_d;
      nos_q      <= nos_d;
      count_q    <= count_d;
      err_q      <= err_d;
      err_code_q <= err_code_d;
    end
  end

  // Array is not reset; reset only suppresses the write.
  always_ff @(posedge clk) begin
    if (rst && mem_we) begin
      mem[mem_wa] <= mem_wd;
    end
  end

  assign dout1    = is_empty ? '0 : tos_q;
  assign dout2    = ge2 ? nos_q : '0;
  assign count    = count_q;
  assign full     = is_full;
  assign empty    = is_empty;
  assign err      = err_q;
  assign err_code = err_code_q;

endmodule

// File: tb/tb_stack_reg_file_p.sv
// Bench for stack_reg_file_p: queue-based stack model checked every cycle plus literal pins.
module tb_stack_reg_file_p;

  localparam int unsigned DBITS = 8;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned CBITS = $clog2(DEPTH + 1);

  logic             clk;
  logic             rst;
  logic [2:0]       op;
  logic [DBITS-1:0] din;
  logic             clr_err;
  logic [DBITS-1:0] dout1;
  logic [DBITS-1:0] dout2;
  logic [CBITS-1:0] count;
  logic             full;
  logic             empty;
  logic             err;
  logic [1:0]       err_code;

  int checks = 0;
  int errors = 0;

  stack_reg_file_p #(.DBITS(DBITS), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .op(op), .din(din), .clr_err(clr_err),
    .dout1(dout1), .dout2(dout2), .count(count), .full(full), .empty(empty),
    .err(err), .err_code(err_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: stack as a queue, back is TOS.
  logic [DBITS-1:0] stk [$];
  logic             m_err = 1'b0;
  logic [1:0]       m_code = 2'b00;

  function automatic void model_reset();
    stk.delete();
    m_err  = 1'b0;
    m_code = 2'b00;
  endfunction

  function automatic void model_step(input logic [2:0] o, input logic [DBITS-1:0] d, input logic c);
    int n;
    logic [1:0] e;
    logic [DBITS-1:0] t;
    n = stk.size();
    e = 2'b00;
    case (o)
      3'd1: if (n == DEPTH) e = 2'b10; else stk.push_back(d);
      3'd2: if (n < 1) e = 2'b01; else void'(stk.pop_back());
      3'd3: if (n < 2) e = 2'b01; else begin void'(stk.pop_back()); void'(stk.pop_back()); end
      3'd4: if (n < 1) e = 2'b01; else stk[n-1] = d;
      3'd5: if (n < 2) e = 2'b01; else begin void'(stk.pop_back()); stk[n-2] = d; end
`ifdef STACK_EXT_OPS_EN
      3'd6: if (n < 1) e = 2'b01; else if (n == DEPTH) e = 2'b10; else stk.push_back(stk[n-1]);
      3'd7: if (n < 2) e = 2'b01; else begin t = stk[n-1]; stk[n-1] = stk[n-2]; stk[n-2] = t; end
`else
      3'd6, 3'd7: e = 2'b11;
`endif
      default: ;
    endcase
    if (e != 2'b00) begin
      if (!(m_err && !c)) m_code = e;
      m_err = 1'b1;
    end else if (c) begin
      m_err  = 1'b0;
      m_code = 2'b00;
    end
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle compare against the model.
  always @(negedge clk) begin
    int n;
    n = stk.size();
    check("m_count", 32'(count), 32'(n));
    check("m_empty", 32'(empty), 32'(n == 0));
    check("m_full", 32'(full), 32'(n == DEPTH));
    check("m_dout1", 32'(dout1), (n >= 1) ? 32'(stk[n-1]) : 32'd0);
    check("m_dout2", 32'(dout2), (n >= 2) ? 32'(stk[n-2]) : 32'd0);
    check("m_err", 32'(err), 32'(m_err));
    check("m_err_code", 32'(err_code), 32'(m_code));
  end

  task automatic step(input logic r, input logic [2:0] o, input logic [DBITS-1:0] d, input logic c);
    rst = r; op = o; din = d; clr_err = c;
    @(posedge clk);
    if (!r) model_reset();
    else model_step(o, d, c);
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b0; op = 3'd0; din = '0; clr_err = 1'b0;

    // Reset then idle
    step(1'b0, 3'd0, 8'h00, 1'b0);
    step(1'b1, 3'd0, 8'h00, 1'b0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_full", 32'(full), 32'd0);
    check("rst_dout1", 32'(dout1), 32'd0);
    check("rst_dout2", 32'(dout2), 32'd0);
    check("rst_err", 32'(err), 32'd0);

    // Push then pop
    step(1'b1, 3'd1, 8'h11, 1'b0);
    step(1'b1, 3'd1, 8'h22, 1'b0);
    step(1'b1, 3'd1, 8'h33, 1'b0);
    check("push3_count", 32'(count), 32'd3);
    check("push3_dout1", 32'(dout1), 32'h33);
    check("push3_dout2", 32'(dout2), 32'h22);
    step(1'b1, 3'd3, 8'h00, 1'b0);
    check("pop2_count", 32'(count), 32'd1);
    check("pop2_dout1", 32'(dout1), 32'h11);
    check("pop2_dout2", 32'(dout2), 32'h00);

    // Binary op
    step(1'b1, 3'd2, 8'h00, 1'b0);
    step(1'b1, 3'd1, 8'h05, 1'b0);
    step(1'b1, 3'd1, 8'h07, 1'b0);
    step(1'b1, 3'd5, 8'h0C, 1'b0);
    check("p2p_count", 32'(count), 32'd1);
    check("p2p_dout1", 32'(dout1), 32'h0C);
    step(1'b1, 3'd4, 8'hFF, 1'b0);
    check("p1p_count", 32'(count), 32'd1);
    check("p1p_dout1", 32'(dout1), 32'hFF);

    // Overflow at DEPTH=4, then drain through the array
    step(1'b0, 3'd0, 8'h00, 1'b0);
    for (int i = 1; i <= 4; i++) step(1'b1, 3'd1, 8'(i), 1'b0);
    check("ovf_full", 32'(full), 32'd1);
    check("ovf_dout1_4", 32'(dout1), 32'd4);
    step(1'b1, 3'd1, 8'd5, 1'b0);
    check("ovf_count", 32'(count), 32'd4);
    check("ovf_dout1", 32'(dout1), 32'd4);
    check("ovf_err", 32'(err), 32'd1);
    check("ovf_code", 32'(err_code), 32'b10);
    step(1'b1, 3'd2, 8'h00, 1'b0);
    check("ovf_pop_count", 32'(count), 32'd3);
    check("ovf_pop_err", 32'(err), 32'd1);
    check("ovf_pop_dout2", 32'(dout2), 32'd2);
    step(1'b1, 3'd1, 8'h44, 1'b0);
    step(1'b1, 3'd3, 8'h00, 1'b0);
    check("deep_pop2_dout1", 32'(dout1), 32'd2);
    check("deep_pop2_dout2", 32'(dout2), 32'd1);

    // Underflow, first-cause retention and clear
    step(1'b0, 3'd0, 8'h00, 1'b0);
    step(1'b1, 3'd2, 8'h00, 1'b0);
    check("unf_err", 32'(err), 32'd1);
    check("unf_code", 32'(err_code), 32'b01);
    check("unf_count", 32'(count), 32'd0);
    step(1'b1, 3'd3, 8'h00, 1'b1);
    check("clr_new_wins", 32'(err_code), 32'b01);
    step(1'b1, 3'd1, 8'h09, 1'b1);
    check("clr_err", 32'(err), 32'd0);
    check("clr_count", 32'(count), 32'd1);

    // Extended ops
    step(1'b0, 3'd0, 8'h00, 1'b0);
    step(1'b1, 3'd1, 8'h0A, 1'b0);
    step(1'b1, 3'd1, 8'h0B, 1'b0);
    step(1'b1, 3'd7, 8'h00, 1'b0);
`ifdef STACK_EXT_OPS_EN
    check("swap_dout1", 32'(dout1), 32'h0A);
    check("swap_dout2", 32'(dout2), 32'h0B);
    step(1'b1, 3'd6, 8'h00, 1'b0);
    check("dup_count", 32'(count), 32'd3);
    check("dup_dout1", 32'(dout1), 32'h0A);
    check("dup_dout2", 32'(dout2), 32'h0A);
`else
    check("ill_code", 32'(err_code), 32'b11);
    check("ill_dout1", 32'(dout1), 32'h0B);
    check("ill_dout2", 32'(dout2), 32'h0A);
    check("ill_count", 32'(count), 32'd2);
`endif

    // Mixed sequence with occasional clear and reset
    for (int i = 0; i < 300; i++) begin
      step(1'($urandom_range(0, 31) != 0), 3'($urandom_range(0, 7)),
           8'($urandom), 1'($urandom_range(0, 7) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
